// File: rtl/bq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bq_pkg
//  Description : Shared types and constants for the biquad filter core.
//                Sample width, divider width, accumulator width, the sample
//                type, the input-conditioner FSM states and a helper that maps
//                an averaging depth to the last sample index of a block.
//  Revision    : 1.0  initial release
// ============================================================================
package bq_pkg;

    localparam int BQ_DW    = 12;
    localparam int BQ_DIV_W = 16;
    localparam int BQ_ACC_W = BQ_DW + 3;

    typedef logic signed [BQ_DW-1:0] bq_sample_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } bq_ic_state_e;

    // Index of the final sample in a block of 2^k samples (k = 0..3).
    function automatic logic [2:0] bq_blk_last(input logic [1:0] k);
        logic [2:0] last;
        case (k)
            2'd0:    last = 3'd0;
            2'd1:    last = 3'd1;
            2'd2:    last = 3'd3;
            default: last = 3'd7;
        endcase
        return last;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bq_input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : bq_input_conditioner_if
//  Description : Output-side bus between the input conditioner and the filter
//                core: averaged sample with valid/ready handshake plus the
//                sticky overrun flag and its clear.
//                  x_o           averaged sample
//                  x_valid_o     x_o holds an unconsumed sample
//                  x_ready_i     consumer accepts x_o
//                  overrun_o     sticky: unconsumed sample was overwritten
//                  clr_overrun_i clears overrun_o
//                master = conditioner side, slave = filter-core side.
//  Revision    : 1.0  initial release
// ============================================================================
interface bq_input_conditioner_if #(
    parameter int DW = 12
) ();

    logic [DW-1:0] x_o;
    logic          x_valid_o;
    logic          x_ready_i;
    logic          overrun_o;
    logic          clr_overrun_i;

    modport master (
        output x_o,
        output x_valid_o,
        output overrun_o,
        input  x_ready_i,
        input  clr_overrun_i
    );

    modport slave (
        input  x_o,
        input  x_valid_o,
        input  overrun_o,
        output x_ready_i,
        output clr_overrun_i
    );

endinterface
`default_nettype wire

// File: rtl/bq_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bq_tick_gen
//  Description : Programmable divider. Counts 0..i_div while i_run is high and
//                pulses o_tick for the cycle in which the count equals i_div,
//                then wraps to 0. i_div is compared live, so lowering it below
//                the current count lets the counter run on to its natural
//                wrap. Deasserting i_run clears the count.
//  Ports       : clk     clock
//                rst_n   asynchronous active-low reset
//                i_run   count enable; count held at 0 when low
//                i_div   period minus one, in clk cycles
//                o_tick  one-cycle pulse at the end of each period
//  Revision    : 1.0  initial release
// ============================================================================
module bq_tick_gen #(
    parameter int DIV_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_run,
    input  wire logic [DIV_W-1:0] i_div,
    output logic                  o_tick
);

    localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_count;
    logic             w_hit;

    assign w_hit  = (r_count == i_div);
    assign o_tick = i_run && w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!i_run || w_hit) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bq_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : bq_input_conditioner
//  Description : Synchronises the asynchronous pad sample bus, samples it on a
//                programmable tick, box-car averages 2^k samples and offers
//                one result per block over a valid/ready handshake.
//  Ports       : bq_clk_i    filter clock
//                nreset      asynchronous active-low reset
//                enable_i    run enable
//                pad_x_i     raw signed sample bus from pads
//                div_i       sample period minus one
//                avg_log2_i  averaging depth k (N = 2^k)
//                out_if      result bus (x_o / x_valid_o / x_ready_i /
//                            overrun_o / clr_overrun_i)
//  Revision    : 1.0  initial release
// ============================================================================
module bq_input_conditioner
    import bq_pkg::*;
#(
    parameter int DW    = BQ_DW,
    parameter int DIV_W = BQ_DIV_W
) (
    input  wire logic             bq_clk_i,
    input  wire logic             nreset,
    input  wire logic             enable_i,
    input  wire logic [DW-1:0]    pad_x_i,
    input  wire logic [DIV_W-1:0] div_i,
    input  wire logic [1:0]       avg_log2_i,
    bq_input_conditioner_if.master out_if
);

    localparam int c_ACC_W = DW + 3;

    logic [DW-1:0]              r_sync1;
    logic [DW-1:0]              r_sync2;
    bq_ic_state_e               r_state;
    bq_ic_state_e               w_state_nxt;
    logic signed [c_ACC_W-1:0]  r_acc;
    logic signed [c_ACC_W-1:0]  w_acc_nxt;
    logic signed [c_ACC_W-1:0]  w_sum;
    logic signed [c_ACC_W-1:0]  w_avg;
    logic [2:0]                 r_scnt;
    logic [2:0]                 w_scnt_nxt;
    logic [1:0]                 r_k;
    logic [1:0]                 w_k_nxt;
    logic [1:0]                 w_k_eff;
    logic [DW-1:0]              r_x;
    logic [DW-1:0]              w_x_nxt;
    logic                       r_valid;
    logic                       w_valid_nxt;
    logic                       r_overrun;
    logic                       w_overrun_nxt;
    logic                       w_run;
    logic                       w_tick;
    logic                       w_load;

    // Two-flop synchroniser; the pads are held stable around each tick so
    // no cross-bit coherency logic is needed.
    always_ff @(posedge bq_clk_i or negedge nreset) begin
        if (!nreset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_x_i;
            r_sync2 <= r_sync1;
        end
    end

    // Counter only runs while accumulating; dropping enable clears it on the
    // same edge the FSM leaves ACCUM.
    assign w_run = (r_state == ACCUM) && enable_i;

    bq_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk    (bq_clk_i),
        .rst_n  (nreset),
        .i_run  (w_run),
        .i_div  (div_i),
        .o_tick (w_tick)
    );

    // Depth is taken live on the first sample of a block, then held.
    assign w_k_eff = (r_scnt == 3'd0) ? avg_log2_i : r_k;
    assign w_sum   = r_acc + $signed({{(c_ACC_W-DW){r_sync2[DW-1]}}, r_sync2});
    assign w_avg   = w_sum >>> w_k_eff;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_scnt_nxt  = r_scnt;
        w_k_nxt     = r_k;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_acc_nxt  = '0;
                w_scnt_nxt = '0;
                if (enable_i) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable_i) begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_scnt_nxt  = '0;
                end else if (w_tick) begin
                    w_k_nxt = w_k_eff;
                    if (r_scnt == bq_blk_last(w_k_eff)) begin
                        w_load     = 1'b1;
                        w_acc_nxt  = '0;
                        w_scnt_nxt = '0;
                    end else begin
                        w_acc_nxt  = w_sum;
                        w_scnt_nxt = r_scnt + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A new result always wins over a same-cycle transfer; an overwrite of an
    // unconsumed result raises overrun, which beats a same-cycle clear.
    always_comb begin
        w_x_nxt       = w_load ? w_avg[DW-1:0] : r_x;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;
        if (w_load) begin
            w_valid_nxt = 1'b1;
        end else if (r_valid && out_if.x_ready_i) begin
            w_valid_nxt = 1'b0;
        end
        if (w_load && r_valid && !out_if.x_ready_i) begin
            w_overrun_nxt = 1'b1;
        end else if (out_if.clr_overrun_i) begin
            w_overrun_nxt = 1'b0;
        end
    end

    always_ff @(posedge bq_clk_i or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge bq_clk_i or negedge nreset) begin
        if (!nreset) begin
            r_acc     <= '0;
            r_scnt    <= '0;
            r_k       <= '0;
            r_x       <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_acc     <= w_acc_nxt;
            r_scnt    <= w_scnt_nxt;
            r_k       <= w_k_nxt;
            r_x       <= w_x_nxt;
            r_valid   <= w_valid_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign out_if.x_o       = r_x;
    assign out_if.x_valid_o = r_valid;
    assign out_if.overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_bq_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bq_input_conditioner
//  Description : Self-checking bench for bq_input_conditioner. Each scenario
//                task drives pads/controls and queues the results it expects;
//                a monitor pops and compares on every handshake transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bq_input_conditioner;
    import bq_pkg::*;

    logic                clk = 1'b0;
    logic                nreset;
    logic                enable;
    logic [BQ_DW-1:0]    pad;
    logic [BQ_DIV_W-1:0] div;
    logic [1:0]          k;

    int          checks = 0;
    int          errors = 0;
    bq_sample_t  exp_q[$];
    bq_sample_t  sb_exp;

    bq_input_conditioner_if #(.DW(BQ_DW)) out_if ();

    bq_input_conditioner #(
        .DW    (BQ_DW),
        .DIV_W (BQ_DIV_W)
    ) dut (
        .bq_clk_i   (clk),
        .nreset     (nreset),
        .enable_i   (enable),
        .pad_x_i    (pad),
        .div_i      (div),
        .avg_log2_i (k),
        .out_if     (out_if)
    );

    always #5 clk = ~clk;

    // Scoreboard: a transfer happens at the next rising edge whenever
    // valid && ready is seen here, so the sample on x_o is the one consumed.
    always @(negedge clk) begin
        if (nreset && out_if.x_valid_o && out_if.x_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got x_o=%h, no result expected", out_if.x_o);
            end else begin
                sb_exp = exp_q.pop_front();
                if (out_if.x_o !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_data got x_o=%h want %h", out_if.x_o, sb_exp);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        nreset = 1'b0; enable = 1'b0; div = 16'd3; k = 2'd0;
        out_if.x_ready_i = 1'b0; out_if.clr_overrun_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pad = 12'($urandom);
            step();
        end
        checks++;
        if (out_if.x_o !== 12'h000) begin errors++; $display("FAIL reset_x got %h want 000", out_if.x_o); end
        checks++;
        if (out_if.x_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_if.x_valid_o); end
        checks++;
        if (out_if.overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", out_if.overrun_o); end
        nreset = 1'b1;
        pad = 12'h2A5;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_if.x_valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", out_if.x_valid_o); end
        end
        // div=3: entry to ACCUM one edge after enable, tick 4 edges later.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_if.x_valid_o !== 1'b0) begin errors++; $display("FAIL pre_tick_valid cycle %0d got %b want 0", i, out_if.x_valid_o); end
        end
        step();
        checks++;
        if (out_if.x_valid_o !== 1'b1) begin errors++; $display("FAIL first_tick_valid got %b want 1", out_if.x_valid_o); end
        checks++;
        if (out_if.x_o !== 12'h2A5) begin errors++; $display("FAIL first_tick_x got %h want 2a5", out_if.x_o); end
        enable = 1'b0;
        step(3);
        checks++;
        if (out_if.x_valid_o !== 1'b1) begin errors++; $display("FAIL pending_hold got %b want 1", out_if.x_valid_o); end
        exp_q.push_back(12'h2A5);
        out_if.x_ready_i = 1'b1;
        step();
        checks++;
        if (out_if.x_valid_o !== 1'b0) begin errors++; $display("FAIL valid_drop got %b want 0", out_if.x_valid_o); end
    endtask

    task automatic test_passthrough;
        k = 2'd0; div = 16'd0; out_if.x_ready_i = 1'b1;
        for (int i = 0; i < 18; i++) begin
            pad    = (i < 16) ? 12'(i) : 12'h00F;
            enable = (i >= 1);
            if (i < 16) exp_q.push_back(12'(i));
            step();
        end
        enable = 1'b0;
        step(3);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL pt_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_averaging;
        bq_sample_t seq [4];
        seq[0] = 12'h7FF; seq[1] = 12'h7FF; seq[2] = 12'h800; seq[3] = 12'h800;
        k = 2'd2; div = 16'd1; out_if.x_ready_i = 1'b1;
        // Any 4 consecutive samples are two of each: sum -2, floor(-2/4) = -1.
        repeat (3) exp_q.push_back(12'hFFF);
        for (int i = 0; i < 25; i++) begin
            pad    = seq[(i / 2) % 4];
            enable = 1'b1;
            step();
        end
        enable = 1'b0;
        step(3);
        repeat (2) exp_q.push_back(12'h123);
        for (int i = 0; i < 17; i++) begin
            pad    = 12'h123;
            enable = 1'b1;
            step();
        end
        enable = 1'b0;
        step(3);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL avg_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure;
        k = 2'd0; div = 16'd4; out_if.x_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pad    = (i < 6) ? 12'h111 : ((i < 11) ? 12'h222 : 12'h333);
            enable = 1'b1;
            step();
        end
        checks++;
        if (out_if.x_o !== 12'h222) begin errors++; $display("FAIL bp_latest got %h want 222", out_if.x_o); end
        checks++;
        if (out_if.x_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", out_if.x_valid_o); end
        checks++;
        if (out_if.overrun_o !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b want 1", out_if.overrun_o); end
        exp_q.push_back(12'h222);
        out_if.x_ready_i = 1'b1;
        enable = 1'b0;
        step();
        checks++;
        if (out_if.x_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_if.x_valid_o); end
        checks++;
        if (out_if.overrun_o !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b want 1", out_if.overrun_o); end
        out_if.clr_overrun_i = 1'b1;
        step();
        out_if.clr_overrun_i = 1'b0;
        checks++;
        if (out_if.overrun_o !== 1'b0) begin errors++; $display("FAIL bp_clear got %b want 0", out_if.overrun_o); end
    endtask

    task automatic test_simultaneous;
        k = 2'd0; div = 16'd2; out_if.x_ready_i = 1'b0; out_if.clr_overrun_i = 1'b0;
        exp_q.push_back(12'h055);
        for (int i = 0; i < 10; i++) begin
            if (i == 7) begin
                checks++;
                if (out_if.x_valid_o !== 1'b1) begin errors++; $display("FAIL sim_load_valid got %b want 1", out_if.x_valid_o); end
                checks++;
                if (out_if.overrun_o !== 1'b0) begin errors++; $display("FAIL sim_load_overrun got %b want 0", out_if.overrun_o); end
                checks++;
                if (out_if.x_o !== 12'h066) begin errors++; $display("FAIL sim_load_x got %h want 066", out_if.x_o); end
            end
            pad    = (i < 3) ? 12'h055 : ((i < 6) ? 12'h066 : 12'h077);
            enable = 1'b1;
            out_if.x_ready_i     = (i == 6);
            out_if.clr_overrun_i = (i == 9);
            step();
        end
        out_if.clr_overrun_i = 1'b0;
        checks++;
        if (out_if.overrun_o !== 1'b1) begin errors++; $display("FAIL sim_set_wins got %b want 1", out_if.overrun_o); end
        checks++;
        if (out_if.x_o !== 12'h077) begin errors++; $display("FAIL sim_overwrite_x got %h want 077", out_if.x_o); end
        exp_q.push_back(12'h077);
        out_if.x_ready_i = 1'b1;
        enable = 1'b0;
        step();
        out_if.clr_overrun_i = 1'b1;
        step();
        out_if.clr_overrun_i = 1'b0;
        checks++;
        if (out_if.overrun_o !== 1'b0) begin errors++; $display("FAIL sim_clear got %b want 0", out_if.overrun_o); end
    endtask

    task automatic test_mid_block;
        k = 2'd3; div = 16'd0; out_if.x_ready_i = 1'b1;
        exp_q.push_back(12'hFFB);
        // Five ticks of a block that must be discarded.
        for (int i = 0; i < 6; i++) begin
            pad    = 12'h700;
            enable = 1'b1;
            step();
        end
        enable = 1'b0;
        pad    = 12'hFFB;
        step(2);
        enable = 1'b1;
        step(8);
        checks++;
        if (out_if.x_valid_o !== 1'b0) begin errors++; $display("FAIL mid_no_early got %b want 0", out_if.x_valid_o); end
        step();
        checks++;
        if (out_if.x_valid_o !== 1'b1) begin errors++; $display("FAIL mid_result_valid got %b want 1", out_if.x_valid_o); end
        enable = 1'b0;
        step(3);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        k = 2'd0; div = 16'd0; out_if.x_ready_i = 1'b0; pad = 12'h5A5;
        enable = 1'b1;
        step(6);
        checks++;
        if (out_if.overrun_o !== 1'b1) begin errors++; $display("FAIL rst_pre_overrun got %b want 1", out_if.overrun_o); end
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if (out_if.x_o !== 12'h000) begin errors++; $display("FAIL rst_async_x got %h want 000", out_if.x_o); end
        checks++;
        if (out_if.x_valid_o !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", out_if.x_valid_o); end
        checks++;
        if (out_if.overrun_o !== 1'b0) begin errors++; $display("FAIL rst_async_overrun got %b want 0", out_if.overrun_o); end
        enable = 1'b0;
        step();
        nreset = 1'b1;
        step(5);
        checks++;
        if (out_if.x_valid_o !== 1'b0) begin errors++; $display("FAIL rst_after_valid got %b want 0", out_if.x_valid_o); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_averaging();
        test_backpressure();
        test_simultaneous();
        test_mid_block();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
